// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
//   - state_e      : occupancy-encoded state of a skid-buffered stage register
//   - EXMEM_*_W    : default control/data widths for the EX/MEM boundary
//   - EXMEM_*_LSB  : bit offsets used when packing the EX/MEM data field
package pipe_pkg;

  // The encoding doubles as the held-entry count, so it is exported
  // unchanged as occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int EXMEM_CTRL_W = 6;
  localparam int EXMEM_DATA_W = 134;

  // EX/MEM data layout, LSB first:
  //   pc_add4[31:0] | zero | rd_index[4:0] | rt_data[31:0] | alu_result[31:0] | instr[31:0]
  localparam int EXMEM_PC_ADD4_LSB = 0;
  localparam int EXMEM_ZERO_BIT    = 32;
  localparam int EXMEM_RD_IDX_LSB  = 33;
  localparam int EXMEM_RT_DATA_LSB = 38;
  localparam int EXMEM_ALU_RES_LSB = 70;
  localparam int EXMEM_INSTR_LSB   = 102;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer.
//
// Handshake: an entry moves across a port on every rising edge where both
// valid and ready are high (accept = in_valid_i & in_ready_o upstream,
// pop = out_valid_o & out_ready_i downstream). valid never depends on ready,
// and in_ready_o is decoded from the state register only, so there is no
// combinational path from out_ready_i to in_ready_o.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset (overrides everything)
//   flush_i      synchronous flush, drops all held entries and any accept
//   in_valid_i   upstream entry valid
//   in_ready_o   stage can take an entry (state != TWO)
//   in_ctrl_i    upstream control field
//   in_data_i    upstream data field
//   out_valid_o  main entry valid (state != EMPTY)
//   out_ready_i  downstream takes the main entry
//   out_ctrl_o   main control field, zero whenever empty
//   out_data_o   main data field
//   occupancy_o  held entries (0..2), equal to the state encoding
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W              = EXMEM_CTRL_W,
  parameter int DATA_W              = EXMEM_DATA_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  state_e            r_state;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  state_e            w_state_nxt;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic              w_accept;
  logic              w_pop;

  assign out_valid_o = (r_state != ST_EMPTY);
  assign in_ready_o  = (r_state != ST_TWO);
  assign occupancy_o = r_state;
  assign out_ctrl_o  = r_main_ctrl;
  assign out_data_o  = r_main_data;

  assign w_accept = in_valid_i & in_ready_o;
  assign w_pop    = out_valid_o & out_ready_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;

    if (flush_i) begin
      // Bubble insertion: any accept this cycle is dropped. A pop this cycle
      // has already been taken by downstream, the rest is discarded.
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        w_main_data_nxt = '0;
        w_skid_data_nxt = '0;
      end
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = in_ctrl_i;
            w_main_data_nxt = in_data_i;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_main_ctrl_nxt = in_ctrl_i;
            w_main_data_nxt = in_data_i;
          end else if (w_accept) begin
            w_state_nxt     = ST_TWO;
            w_skid_ctrl_nxt = in_ctrl_i;
            w_skid_data_nxt = in_data_i;
          end else if (w_pop) begin
            // Going empty: clear ctrl so no enables leak downstream as a
            // bubble; data is left as-is.
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = '0;
          end
        end
        ST_TWO: begin
          // in_ready_o is low here, so only a pop can happen.
          if (w_pop) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = '0;
          end
        end
        default: begin
          w_state_nxt     = ST_EMPTY;
          w_main_ctrl_nxt = '0;
          w_skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;
  localparam int CW = 6;
  localparam int DW = 134;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          out_ready_i;
  logic [CW-1:0] in_ctrl_i;
  logic [DW-1:0] in_data_i;

  logic          in_ready_o, out_valid_o;
  logic [CW-1:0] out_ctrl_o;
  logic [DW-1:0] out_data_o;
  logic [1:0]    occupancy_o;

  // Second instance: identical stimulus, data kept on flush.
  logic          nc_in_ready_o, nc_out_valid_o;
  logic [CW-1:0] nc_out_ctrl_o;
  logic [DW-1:0] nc_out_data_o;
  logic [1:0]    nc_occupancy_o;

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
    .occupancy_o(occupancy_o)
  );

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b0)) u_dut_nc (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(nc_in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(nc_out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(nc_out_ctrl_o), .out_data_o(nc_out_data_o),
    .occupancy_o(nc_occupancy_o)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // A 2-deep FIFO: ready reflects the depth at the start of the cycle.
  // When empty, ctrl reads 0 and data shows the last entry that was at the
  // head (or 0 after reset / clearing flush).
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] ctrl_q[$];
  logic [DW-1:0] held_clr;
  logic [DW-1:0] held_keep;

  logic          e_valid, e_ready;
  logic [1:0]    e_occ;
  logic [CW-1:0] e_ctrl;
  logic [DW-1:0] e_data_clr, e_data_keep;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i += 32) d = {d[DW-33:0], $urandom()};
    return d;
  endfunction

  task automatic refresh_expect();
    e_valid     = (exp_q.size() != 0);
    e_ready     = (exp_q.size() < 2);
    e_occ       = 2'(exp_q.size());
    e_ctrl      = e_valid ? ctrl_q[0] : '0;
    e_data_clr  = e_valid ? exp_q[0] : held_clr;
    e_data_keep = e_valid ? exp_q[0] : held_keep;
  endtask

  // Drives one cycle (called at posedge+1), advances the model, and returns
  // at the next posedge+1 where outputs are sampled.
  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
    logic acc, pop;
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    acc = v && (exp_q.size() < 2);
    pop = r && (exp_q.size() != 0);
    if (!rst_i) begin
      exp_q.delete(); ctrl_q.delete();
      held_clr = '0; held_keep = '0;
    end else if (f) begin
      exp_q.delete(); ctrl_q.delete();
      held_clr = '0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(ctrl_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(d);
        ctrl_q.push_back(c);
      end
    end
    if (exp_q.size() != 0) begin
      held_clr  = exp_q[0];
      held_keep = exp_q[0];
    end
    @(posedge clk);
    #1;
    refresh_expect();
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, '0, '0, r, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b0;
    cycle(1'b1, 6'h3F, 134'h5A, 1'b0, 1'b0);
    cycle(1'b1, 6'h3F, 134'h5B, 1'b0, 1'b0);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
    total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
    total++; if (out_ctrl_o !== '0 || out_data_o !== '0 || nc_out_data_o !== '0) begin
      bad++; $display("FAIL reset_fields ctrl=%h data=%h nc_data=%h exp=0", out_ctrl_o, out_data_o, nc_out_data_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 6'(k), DW'(k), 1'b1, 1'b0);
      total++;
      if (out_data_o !== DW'(k) || occupancy_o !== 2'd1 || !out_valid_o) begin
        bad++; $display("FAIL stream_%0d data=%h occ=%0d valid=%b exp data=%0d occ=1 valid=1",
                        k, out_data_o, occupancy_o, out_valid_o, k);
      end
    end
    idle(1'b1);
    total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== '0) begin
      bad++; $display("FAIL stream_drain valid=%b ctrl=%h exp 0/0", out_valid_o, out_ctrl_o);
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 6'h01, 134'h11, 1'b0, 1'b0);
    cycle(1'b1, 6'h02, 134'h22, 1'b0, 1'b0);
    total++; if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== 134'h11) begin
      bad++; $display("FAIL bp_full occ=%0d ready=%b data=%h exp 2/0/11", occupancy_o, in_ready_o, out_data_o);
    end
    cycle(1'b1, 6'h03, 134'h99, 1'b0, 1'b0);  // refused: ready is low
    total++; if (out_data_o !== 134'h11 || out_ctrl_o !== 6'h01 || occupancy_o !== 2'd2) begin
      bad++; $display("FAIL bp_stable data=%h ctrl=%h occ=%0d exp 11/01/2", out_data_o, out_ctrl_o, occupancy_o);
    end
    idle(1'b1);
    total++; if (out_data_o !== 134'h22 || out_ctrl_o !== 6'h02 || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL bp_pop1 data=%h ctrl=%h occ=%0d ready=%b exp 22/02/1/1",
                      out_data_o, out_ctrl_o, occupancy_o, in_ready_o);
    end
    idle(1'b1);
    total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== '0 || out_data_o !== 134'h22) begin
      bad++; $display("FAIL bp_empty valid=%b ctrl=%h data=%h exp 0/0/22", out_valid_o, out_ctrl_o, out_data_o);
    end
  endtask

  task automatic test_flush_full();
    cycle(1'b1, 6'h3F, 134'hA1, 1'b0, 1'b0);
    cycle(1'b1, 6'h3F, 134'hA2, 1'b0, 1'b0);
    cycle(1'b1, 6'h3F, 134'h33, 1'b0, 1'b1);
    total++; if (occupancy_o !== 2'd0 || out_ctrl_o !== '0 || out_data_o !== '0 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_full occ=%0d ctrl=%h data=%h ready=%b exp 0/0/0/1",
                      occupancy_o, out_ctrl_o, out_data_o, in_ready_o);
    end
    total++; if (nc_out_data_o !== 134'hA1 || nc_out_ctrl_o !== '0) begin
      bad++; $display("FAIL flush_full_nc data=%h ctrl=%h exp a1/0", nc_out_data_o, nc_out_ctrl_o);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      total++; if (out_valid_o !== 1'b0 || out_data_o === 134'h33) begin
        bad++; $display("FAIL flush_dropped_%0d valid=%b data=%h exp valid=0", i, out_valid_o, out_data_o);
      end
    end
  endtask

  task automatic test_flush_keep_data();
    cycle(1'b1, 6'h15, 134'h44, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    total++; if (nc_out_ctrl_o !== '0 || nc_out_data_o !== 134'h44 || nc_out_valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_keep ctrl=%h data=%h valid=%b exp 0/44/0",
                      nc_out_ctrl_o, nc_out_data_o, nc_out_valid_o);
    end
  endtask

  task automatic test_accept_pop();
    cycle(1'b1, 6'h05, 134'h55, 1'b0, 1'b0);
    cycle(1'b1, 6'h06, 134'h66, 1'b1, 1'b0);
    total++; if (occupancy_o !== 2'd1 || out_data_o !== 134'h66 || out_ctrl_o !== 6'h06) begin
      bad++; $display("FAIL accept_pop occ=%0d data=%h ctrl=%h exp 1/66/06", occupancy_o, out_data_o, out_ctrl_o);
    end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 6'h2A, 134'h77, 1'b0, 1'b0);
    cycle(1'b1, 6'h2B, 134'h88, 1'b0, 1'b0);
    rst_i = 1'b0;
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    rst_i = 1'b1;
    total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || occupancy_o !== 2'd0 ||
                 out_ctrl_o !== '0 || out_data_o !== '0 || nc_out_data_o !== '0) begin
      bad++; $display("FAIL reset_mid valid=%b ready=%b occ=%0d ctrl=%h data=%h exp 0/1/0/0/0",
                      out_valid_o, in_ready_o, occupancy_o, out_ctrl_o, out_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      total++; if (out_valid_o !== 1'b0) begin
        bad++; $display("FAIL reset_mid_emit_%0d valid=%b data=%h exp valid=0", i, out_valid_o, out_data_o);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 6'($urandom()), rand_data(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      total++;
      if (out_valid_o !== e_valid || in_ready_o !== e_ready || occupancy_o !== e_occ ||
          out_ctrl_o !== e_ctrl || out_data_o !== e_data_clr) begin
        bad++; $display("FAIL rand_%0d v=%b r=%b occ=%0d ctrl=%h data=%h exp v=%b r=%b occ=%0d ctrl=%h data=%h",
                        i, out_valid_o, in_ready_o, occupancy_o, out_ctrl_o, out_data_o,
                        e_valid, e_ready, e_occ, e_ctrl, e_data_clr);
      end
      total++;
      if (nc_out_valid_o !== e_valid || nc_out_ctrl_o !== e_ctrl || nc_out_data_o !== e_data_keep) begin
        bad++; $display("FAIL rand_nc_%0d v=%b ctrl=%h data=%h exp v=%b ctrl=%h data=%h",
                        i, nc_out_valid_o, nc_out_ctrl_o, nc_out_data_o, e_valid, e_ctrl, e_data_keep);
      end
    end
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_ctrl_i = '0; in_data_i = '0;
    held_clr = '0; held_keep = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_keep_data();
    test_accept_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
